// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a synchronous-read InstMem and hands
// {pc, instruction} pairs to decode through a 2-entry buffer with valid/ready handshake.
module inst_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,

    output logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       mem_q,

    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,

    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst_data,

    output logic              fetch_err
);

    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_data_q, head_data_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_data_q, tail_data_d;
    logic        valid_q, valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit_used;

    // Issue only when the buffer can absorb everything already requested.
    always_comb begin
        pop         = valid_q & inst_ready;
        push        = inflight_q & ~redirect_valid;
        credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = ~redirect_valid & (credit_used < 3'd2);
    end

    always_comb begin
        req_pc_d      = req_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        head_pc_d     = head_pc_q;
        head_data_d   = head_data_q;
        tail_pc_d     = tail_pc_q;
        tail_data_d   = tail_data_q;
        fetch_err_d   = fetch_err_q;

        if (redirect_valid) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            req_pc_d   = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_d = 1'b1;
            end
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = req_pc_q;
                req_pc_d      = req_pc_q + 32'd4;
            end else begin
                inflight_d    = 1'b0;
            end

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d   = inflight_pc_q;
                        head_data_d = mem_q;
                    end else begin
                        tail_pc_d   = inflight_pc_q;
                        tail_data_d = mem_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d   = tail_pc_q;
                    head_data_d = tail_data_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_pc_d   = inflight_pc_q;
                        head_data_d = mem_q;
                    end else begin
                        head_pc_d   = tail_pc_q;
                        head_data_d = tail_data_q;
                        tail_pc_d   = inflight_pc_q;
                        tail_data_d = mem_q;
                    end
                end
                default: begin
                end
            endcase
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            req_pc_q      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            count_q       <= 2'd0;
            head_pc_q     <= 32'd0;
            head_data_q   <= 32'd0;
            tail_pc_q     <= 32'd0;
            tail_data_q   <= 32'd0;
            valid_q       <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            req_pc_q      <= req_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_pc_q     <= head_pc_d;
            head_data_q   <= head_data_d;
            tail_pc_q     <= tail_pc_d;
            tail_data_q   <= tail_data_d;
            valid_q       <= valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign mem_address = req_pc_q[ADDR_W+1:2];
    assign inst_valid  = valid_q;
    assign inst_pc     = head_pc_q;
    assign inst_data   = head_data_q;
    assign fetch_err   = fetch_err_q;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && count_q == 2'd2));
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: an ideal-stream model checked every cycle, plus directed
// literal checks following the fetch test plan.
module tb_inst_fetch_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_q = 32'd0;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_pc;
    logic [31:0]       inst_data;
    logic              fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rom [1024];

    inst_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_q          (mem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | i;
    end

    always @(posedge clk) mem_q <= rom[mem_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA000_0000 | {22'd0, pc[11:2]};
    endfunction

    // Model: decode sees an unbroken ascending pc stream from the last restart point;
    // the head is valid from the second edge after a restart onwards.
    logic [31:0] exp_pc;
    logic [31:0] restart_pc;
    logic        exp_err;
    logic        last_was_reset;
    int          age;
    bit          seen = 1'b0;

    always @(negedge clk) begin
        if (seen) begin
            chk("valid", {31'd0, inst_valid}, {31'd0, (age >= 2)});
            chk("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
            if (inst_valid) begin
                chk("head_pc", inst_pc, exp_pc);
                chk("head_data", inst_data, word_of(exp_pc));
            end
            if (age == 0) begin
                chk("restart_addr", {22'd0, mem_address}, {22'd0, restart_pc[11:2]});
                if (last_was_reset) begin
                    chk("rst_pc", inst_pc, 32'd0);
                    chk("rst_data", inst_data, 32'd0);
                end
            end
        end
        if (!reset_n) begin
            seen           = 1'b1;
            exp_pc         = RESET_PC;
            restart_pc     = RESET_PC;
            exp_err        = 1'b0;
            last_was_reset = 1'b1;
            age            = 0;
        end else if (seen) begin
            if (redirect_valid) begin
                exp_pc         = {redirect_pc[31:2], 2'b00};
                restart_pc     = exp_pc;
                last_was_reset = 1'b0;
                age            = 0;
                if (redirect_pc[1:0] != 2'b00) exp_err = 1'b1;
            end else begin
                if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
                if (age < 2) age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset and first fetch latency.
        repeat (3) tick();
        chk("t1_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("t1_rst_addr", {22'd0, mem_address}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("t1_e1_valid", {31'd0, inst_valid}, 32'd0);
        chk("t1_e1_addr", {22'd0, mem_address}, 32'd1);
        tick();
        chk("t1_e2_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_e2_pc", inst_pc, 32'h0);
        chk("t1_e2_data", inst_data, 32'hA000_0000);
        tick();
        chk("t1_e3_pc", inst_pc, 32'h4);
        tick();
        chk("t1_e4_pc", inst_pc, 32'h8);

        // Backpressure with head at 0x8.
        inst_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("t2_stall_pc", inst_pc, 32'h8);
            chk("t2_stall_data", inst_data, 32'hA000_0002);
        end
        chk("t2_park_addr", {22'd0, mem_address}, 32'd4);
        inst_ready = 1'b1;
        tick();
        chk("t2_rel1_pc", inst_pc, 32'hC);
        tick();
        chk("t2_rel2_pc", inst_pc, 32'h10);

        // Redirect while head is 0x10.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_r0_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("t3_r1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("t3_r2_pc", inst_pc, 32'h100);
        chk("t3_r2_data", inst_data, 32'hA000_0040);
        repeat (16) tick();
        chk("t3_run_pc", inst_pc, 32'h140);

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("t4_err", {31'd0, fetch_err}, 32'd1);
        repeat (2) tick();
        chk("t4_pc", inst_pc, 32'h100);
        chk("t4_data", inst_data, 32'hA000_0040);
        repeat (3) tick();
        chk("t4_err_sticky", {31'd0, fetch_err}, 32'd1);

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        chk("b2b_pc", inst_pc, 32'h300);
        chk("b2b_data", inst_data, 32'hA000_00C0);

        // Address wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        chk("t5_pc0", inst_pc, 32'hFF8);
        chk("t5_data0", inst_data, 32'hA000_03FE);
        tick();
        chk("t5_pc1", inst_pc, 32'hFFC);
        chk("t5_data1", inst_data, 32'hA000_03FF);
        tick();
        chk("t5_pc2", inst_pc, 32'h1000);
        chk("t5_data2", inst_data, 32'hA000_0000);

        // Reset mid-operation with a full buffer.
        inst_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("t6_valid", {31'd0, inst_valid}, 32'd0);
        chk("t6_addr", {22'd0, mem_address}, 32'd0);
        chk("t6_err", {31'd0, fetch_err}, 32'd0);
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("t6_e1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("t6_e2_pc", inst_pc, 32'h0);
        chk("t6_e2_data", inst_data, 32'hA000_0000);
        tick();
        chk("t6_e3_pc", inst_pc, 32'h4);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
